// File: rtl/mandel_view_loader.sv
// rtl/mandel_view_loader.sv - view-parameter shadow/active register loader
// Host writes land in shadow registers; the active set updates atomically at frame start.
module mandel_view_loader #(
  parameter int                  BITS       = 16,
  parameter int                  INC_BITS   = 12,
  parameter logic [BITS-1:0]     X_LEFT_RST = 16'hA800,
  parameter logic [BITS-1:0]     Y_TOP_RST  = 16'h3400,
  parameter logic [INC_BITS-1:0] X_INC_RST  = INC_BITS'(240),
  parameter logic [INC_BITS-1:0] Y_INC_RST  = INC_BITS'(51)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [13:0]         value_in,
  input  logic [1:0]          sel,
  input  logic                wr_en,
  input  logic                frame_start,
  output logic [BITS-1:0]     x_left,
  output logic [BITS-1:0]     y_top,
  output logic [INC_BITS-1:0] x_inc,
  output logic [INC_BITS-1:0] y_inc,
  output logic                pending,
  output logic                committed
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                state;
  logic [2:0]            wr_sync;
  logic                  wr_rise;
  logic                  commit;
  logic signed [14:0]    scaled;
  logic [BITS-1:0]       coord_val;
  logic [INC_BITS-1:0]   inc_val;
  logic [BITS-1:0]       sh_x_left;
  logic [BITS-1:0]       sh_y_top;
  logic [INC_BITS-1:0]   sh_x_inc;
  logic [INC_BITS-1:0]   sh_y_inc;

  // wr_sync[1:0] is the synchroniser, wr_sync[2] the edge-detect history
  assign wr_rise = wr_sync[1] & ~wr_sync[2];
  assign commit  = frame_start && (state == PENDING);

  // Q2.12 host value becomes Q3.13: sign-extend, then shift left by one
  assign scaled    = signed'({value_in, 1'b0});
  assign coord_val = BITS'(scaled);
  assign inc_val   = value_in[INC_BITS-1:0];

  assign pending = (state == PENDING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sync   <= 3'b000;
      state     <= IDLE;
      committed <= 1'b0;
      sh_x_left <= X_LEFT_RST;
      sh_y_top  <= Y_TOP_RST;
      sh_x_inc  <= X_INC_RST;
      sh_y_inc  <= Y_INC_RST;
      x_left    <= X_LEFT_RST;
      y_top     <= Y_TOP_RST;
      x_inc     <= X_INC_RST;
      y_inc     <= Y_INC_RST;
    end else begin
      wr_sync   <= {wr_sync[1:0], wr_en};
      committed <= commit;

      // Active set copies the pre-write shadow even if a write lands on this edge
      if (commit) begin
        x_left <= sh_x_left;
        y_top  <= sh_y_top;
        x_inc  <= sh_x_inc;
        y_inc  <= sh_y_inc;
      end

      if (wr_rise) begin
        case (sel)
          2'd0:    sh_x_left <= coord_val;
          2'd1:    sh_y_top  <= coord_val;
          2'd2:    sh_x_inc  <= inc_val;
          default: sh_y_inc  <= inc_val;
        endcase
      end

      case (state)
        IDLE:    if (wr_rise) state <= PENDING;
        PENDING: if (frame_start && !wr_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_view_loader.sv
// tb/tb_mandel_view_loader.sv - self-checking bench for mandel_view_loader
// Reference model: shadow/active arrays updated by the write and commit rules at each clock edge.
module tb_mandel_view_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value_in = '0;
  logic [1:0]  sel = '0;
  logic        wr_en = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] x_left, y_top;
  logic [11:0] x_inc, y_inc;
  logic        pending, committed;

  int cmp_count = 0;
  int err_count = 0;

  mandel_view_loader dut (
    .clk(clk), .reset(reset), .value_in(value_in), .sel(sel), .wr_en(wr_en),
    .frame_start(frame_start), .x_left(x_left), .y_top(y_top), .x_inc(x_inc),
    .y_inc(y_inc), .pending(pending), .committed(committed)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_sh[4];
  logic [15:0] m_act[4];
  logic        m_pend, m_comm, m_prev_w;
  int          m_edge;
  int          m_sched[$];

  function automatic logic [15:0] conv(input logic [1:0] s, input logic [13:0] v);
    int sv;
    sv = int'($signed(v));
    if (s < 2) return 16'(sv * 2);
    return 16'(v % 4096);
  endfunction

  task automatic model_reset();
    m_sh[0] = 16'hA800; m_sh[1] = 16'h3400; m_sh[2] = 16'd240; m_sh[3] = 16'd51;
    m_act = m_sh;
    m_pend = 1'b0; m_comm = 1'b0; m_prev_w = 1'b0;
    m_edge = 0;
    m_sched.delete();
  endtask

  task automatic model_edge();
    bit do_write;
    m_edge++;
    do_write = (m_sched.size() > 0 && m_sched[0] == m_edge);
    if (do_write) void'(m_sched.pop_front());
    if (frame_start && m_pend) begin
      m_act = m_sh; m_comm = 1'b1; m_pend = 1'b0;
    end else begin
      m_comm = 1'b0;
    end
    if (do_write) begin
      m_sh[sel] = conv(sel, value_in);
      m_pend = 1'b1;
    end
    // A rise first sampled on this edge reaches the shadow two edges later
    if (wr_en && !m_prev_w) m_sched.push_back(m_edge + 2);
    m_prev_w = wr_en;
  endtask

  task automatic tick(input logic fs, input logic w);
    frame_start = fs;
    wr_en = w;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    cmp_count++; if (x_left !== 16'hA800) begin err_count++; $display("FAIL reset_x_left: got %h expected %h", x_left, 16'hA800); end
    cmp_count++; if (y_top !== 16'h3400) begin err_count++; $display("FAIL reset_y_top: got %h expected %h", y_top, 16'h3400); end
    cmp_count++; if (x_inc !== 12'd240) begin err_count++; $display("FAIL reset_x_inc: got %0d expected 240", x_inc); end
    cmp_count++; if (y_inc !== 12'd51) begin err_count++; $display("FAIL reset_y_inc: got %0d expected 51", y_inc); end
    cmp_count++; if (pending !== 1'b0) begin err_count++; $display("FAIL reset_pending: got %b expected 0", pending); end
    cmp_count++; if (committed !== 1'b0) begin err_count++; $display("FAIL reset_committed: got %b expected 0", committed); end
  endtask

  task automatic test_x_left_write();
    sel = 2'd0; value_in = 14'h3000;
    tick(0, 1);
    tick(0, 0);
    cmp_count++; if (pending !== 1'b0) begin err_count++; $display("FAIL xl_early_pending: got %b expected 0", pending); end
    tick(0, 0);
    cmp_count++; if (pending !== 1'b1) begin err_count++; $display("FAIL xl_pending: got %b expected 1", pending); end
    cmp_count++; if (x_left !== 16'hA800) begin err_count++; $display("FAIL xl_hold: got %h expected %h", x_left, 16'hA800); end
    tick(0, 0);
    tick(1, 0);
    cmp_count++; if (x_left !== 16'hE000) begin err_count++; $display("FAIL xl_commit: got %h expected %h", x_left, 16'hE000); end
    cmp_count++; if (committed !== 1'b1) begin err_count++; $display("FAIL xl_committed: got %b expected 1", committed); end
    cmp_count++; if (pending !== 1'b0) begin err_count++; $display("FAIL xl_pending_clr: got %b expected 0", pending); end
    tick(0, 0);
    cmp_count++; if (committed !== 1'b0) begin err_count++; $display("FAIL xl_pulse_len: got %b expected 0", committed); end
  endtask

  task automatic test_inc_writes();
    sel = 2'd2; value_in = 14'h0078;
    tick(0, 1); repeat (3) tick(0, 0);
    sel = 2'd3; value_in = 14'h1033;
    tick(0, 1); repeat (3) tick(0, 0);
    tick(1, 0);
    cmp_count++; if (x_inc !== 12'd120) begin err_count++; $display("FAIL inc_x: got %0d expected 120", x_inc); end
    cmp_count++; if (y_inc !== 12'd51) begin err_count++; $display("FAIL inc_y: got %0d expected 51", y_inc); end
    cmp_count++; if (x_left !== 16'hE000 || y_top !== 16'h3400) begin err_count++; $display("FAIL inc_coords: got %h/%h expected e000/3400", x_left, y_top); end
    tick(0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 2'd1; value_in = 14'h0800;
    tick(0, 1); repeat (3) tick(0, 0);
    sel = 2'd2; value_in = 14'h0064;
    tick(0, 1); tick(0, 0);
    tick(1, 0);
    cmp_count++; if (y_top !== 16'h1000) begin err_count++; $display("FAIL b2b_y_top: got %h expected 1000", y_top); end
    cmp_count++; if (x_inc !== 12'd120) begin err_count++; $display("FAIL b2b_x_inc_old: got %0d expected 120", x_inc); end
    cmp_count++; if (pending !== 1'b1) begin err_count++; $display("FAIL b2b_pending: got %b expected 1", pending); end
    cmp_count++; if (committed !== 1'b1) begin err_count++; $display("FAIL b2b_committed: got %b expected 1", committed); end
    tick(0, 0); tick(1, 0);
    cmp_count++; if (x_inc !== 12'd100) begin err_count++; $display("FAIL b2b_x_inc_new: got %0d expected 100", x_inc); end
    cmp_count++; if (pending !== 1'b0) begin err_count++; $display("FAIL b2b_pending_clr: got %b expected 0", pending); end
    tick(0, 0);
  endtask

  task automatic test_held_high();
    sel = 2'd3; value_in = 14'h2005;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) value_in = 14'h0777;
      tick(0, 1);
    end
    tick(0, 0);
    cmp_count++; if (pending !== 1'b1) begin err_count++; $display("FAIL held_pending: got %b expected 1", pending); end
    tick(1, 0);
    cmp_count++; if (y_inc !== 12'd5) begin err_count++; $display("FAIL held_single_write: got %h expected 005", y_inc); end
    tick(0, 0);
    tick(1, 0);
    cmp_count++; if (committed !== 1'b0) begin err_count++; $display("FAIL idle_frame_committed: got %b expected 0", committed); end
    tick(0, 0);
    cmp_count++; if (committed !== 1'b0 || y_inc !== 12'd5) begin err_count++; $display("FAIL idle_frame_state: got %b/%h expected 0/005", committed, y_inc); end
  endtask

  task automatic test_reset_mid_write();
    sel = 2'd0; value_in = 14'h1234;
    tick(0, 1); tick(0, 1);
    reset = 1'b1; wr_en = 1'b0;
    #1;
    cmp_count++; if (x_left !== 16'hA800 || y_top !== 16'h3400 || x_inc !== 12'd240 || y_inc !== 12'd51) begin
      err_count++; $display("FAIL rst_mid_outputs: got %h %h %0d %0d expected a800 3400 240 51", x_left, y_top, x_inc, y_inc);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    repeat (4) tick(0, 0);
    cmp_count++; if (pending !== 1'b0) begin err_count++; $display("FAIL rst_mid_pending: got %b expected 0", pending); end
    tick(1, 0);
    cmp_count++; if (x_left !== 16'hA800 || committed !== 1'b0) begin err_count++; $display("FAIL rst_mid_discard: got %h/%b expected a800/0", x_left, committed); end
  endtask

  task automatic test_random();
    logic w, fs;
    for (int b = 0; b < 60; b++) begin
      sel = 2'($urandom_range(0, 3));
      value_in = 14'($urandom);
      for (int i = 0; i < 6; i++) begin
        w  = (i == 1 && ($urandom % 5 != 0)) || ((i == 2 || i == 3) && w && ($urandom % 2 == 1));
        fs = ($urandom % 4 == 0);
        tick(fs, w);
        cmp_count++;
        if ({x_left, y_top, x_inc, y_inc, pending, committed} !==
            {m_act[0], m_act[1], m_act[2][11:0], m_act[3][11:0], m_pend, m_comm}) begin
          err_count++;
          $display("FAIL random_b%0d_c%0d: got %h %h %h %h %b %b expected %h %h %h %h %b %b", b, i,
                   x_left, y_top, x_inc, y_inc, pending, committed,
                   m_act[0], m_act[1], m_act[2][11:0], m_act[3][11:0], m_pend, m_comm);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_x_left_write();
    test_inc_writes();
    test_back_to_back();
    test_held_high();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/mandel_view_loader.md
# mandel_view_loader

Host-facing view-parameter loader for the Mandelbrot renderer. It captures view parameters from the dedicated input pins: left-edge x, top-edge y, x step and y step. The host writes them through an asynchronous strobe into shadow registers. The shadow registers are copied atomically into the active set at the next frame start. The active outputs feed the pixel/row coordinate stepping logic in place of its compile-time constants, so the view never changes mid-frame.

## Interface

Parameters:
- `BITS`, default 16: coordinate width, signed fixed point Q3.(BITS-3).
- `INC_BITS`, default 12: step width, unsigned, same LSB weight as coordinates.
- `X_LEFT_RST`, default 16'hA800: reset x_left (-2.75).
- `Y_TOP_RST`, default 16'h3400: reset y_top (1.625).
- `X_INC_RST`, default 240: reset x_inc.
- `Y_INC_RST`, default 51: reset y_inc.

Ports:
- `clk`, input, 1: single clock; all logic in this domain.
- `reset`, input, 1: asynchronous, active-high reset.
- `value_in`, input, 14: host data, signed Q2.12, pins [1:-12].
- `sel`, input, 2: target register; 0=x_left, 1=y_top, 2=x_inc, 3=y_inc.
- `wr_en`, input, 1: asynchronous host write strobe; each rising edge is one write.
- `frame_start`, input, 1: one-cycle pulse from the VGA timing block (vsync pulse).
- `x_left`, output, BITS: active left-edge x.
- `y_top`, output, BITS: active top-edge y.
- `x_inc`, output, INC_BITS: active x step per pixel.
- `y_inc`, output, INC_BITS: active y step per row.
- `pending`, output, 1: shadow set differs from the active set and awaits commit.
- `committed`, output, 1: one-cycle pulse after an active-set update.

## Operation

- `wr_en` passes through a 2-flop synchroniser, then a third flop for edge detection.
- `wr_rise` is defined as sync2 & ~sync3. Only rising edges count; a held-high level produces a single write.
- On `wr_rise`, `value_in` and `sel` are sampled directly; they are not synchronised.
  - The host holds `value_in` and `sel` stable from 1 cycle before the `wr_en` rise until 4 cycles after it.
- Format conversion on write:
  - x_left / y_top shadow = {value_in[13], value_in[13:0], 1'b0}, i.e. sign-extended and scaled to Q3.13. For BITS≠16, sign-extend to BITS-1 bits, then append 0.
  - x_inc / y_inc shadow = value_in[INC_BITS-1:0]. Upper bits are ignored. Zero is legal and gives a constant coordinate.
- Any write sets `pending`. Rewriting the same value still sets it.
- Commit happens when `frame_start`=1 and `pending`=1 on a clock edge:
  - all four shadow registers are copied to the active outputs on that edge;
  - `pending` clears;
  - `committed`=1 for exactly the following cycle.
- `frame_start` with `pending`=0: no change, and `committed` stays 0.
- Simultaneous `wr_rise` and commit on the same edge:
  - the active set takes the shadow contents from before the write;
  - the shadow register takes the new value;
  - `pending` stays 1, so the new value commits at the next frame_start.
- Multiple writes within one frame: the last write per register wins. Registers not written keep their previous shadow value.
- State is two-level: IDLE (pending=0) and PENDING (pending=1).
  - IDLE to PENDING on wr_rise.
  - PENDING to IDLE on frame_start without a simultaneous wr_rise.

## Timing

- Reset (async assert, released synchronously by the integrator):
  - shadow and active registers = the `*_RST` parameters;
  - `pending`=0, `committed`=0;
  - synchroniser flops = 0.
- `wr_en` high before edge N (where edge N first samples it high) → shadow update and `pending`=1 visible after edge N+2.
- Reset asserted mid-write or mid-frame: everything returns to reset values immediately, and any pending write is discarded.
- A `wr_en` that is already high when reset deasserts counts as one write, since sync3=0 at reset.
- Outputs are registered. The active set changes only on a commit edge, and consumers sample it at frame_start+1.
- Writes are accepted at most once every 2 cycles; closer strobes are a host error.

## Test plan

- Reset → x_left=16'hA800, y_top=16'h3400, x_inc=240, y_inc=51, pending=0, committed=0.
- Write sel=0, value_in=14'h3000 (-1.0) → shadow x_left=16'hE000 after the 3-cycle latency; pending=1; x_left output unchanged until frame_start, then 16'hE000 with a one-cycle committed pulse.
- Write sel=2 with value_in=14'h0078, then sel=3 with value_in=14'h1033, then frame_start → x_inc=120, y_inc=51 (upper bits dropped); x_left and y_top unchanged.
- wr_rise coinciding with frame_start while pending=1 (earlier y_top write of 14'h0800 → 16'h1000, then x_inc=14'h0064 arriving on the commit edge):
  - y_top commits as 16'h1000, x_inc stays at its old value, pending stays 1;
  - the next frame_start commits x_inc=100.
- wr_en held high for 50 cycles → exactly one write; frame_start with pending=0 → committed stays 0.
- Reset asserted 1 cycle after a wr_en rise → no shadow change, pending=0, all outputs at reset values.
